// File: rtl/cpu_pkg.sv
// Shared types and constants for the multiply/divide unit.
// Holds the FSM state enum, command encodings and the iteration count.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MULT_RUN,
    DIV_RUN,
    FINISH
  } md_state_e;

  localparam logic [1:0] MD_IDLE = 2'b00;
  localparam logic [1:0] MD_MULT = 2'b01;
  localparam logic [1:0] MD_DIV  = 2'b10;

  localparam int unsigned MD_ITER = 32;

  function automatic logic [31:0] md_abs(input logic [31:0] v);
    return v[31] ? 32'(32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/md_addsub.sv
// 33-bit combinational adder/subtractor shared by the Booth and restoring-divide steps.
module md_addsub (
  input  logic [32:0] x,
  input  logic [32:0] y,
  input  logic        sub,
  output logic [32:0] sum
);

  always_comb begin
    sum = sub ? (x - y) : (x + y);
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) and divide (restoring) unit.
// One step per cycle; results land in HI/LO on the FINISH edge.
module mult_div_unit
  import cpu_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  mult_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div0
);

  localparam logic [5:0] LastCnt = 6'(MD_ITER - 1);

  md_state_e   state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [32:0] acc_q, acc_d;     // Booth upper half, or partial remainder
  logic [31:0] qr_q, qr_d;       // multiplier / product low word, or quotient
  logic        qm1_q, qm1_d;     // Booth q[-1]
  logic [32:0] mcand_q, mcand_d; // sign-extended multiplicand, or divisor magnitude
  logic        is_div_q, is_div_d;
  logic        zero_div_q, zero_div_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        done_q, done_d, div0_q, div0_d;

  logic [32:0] as_x, as_y, as_sum;
  logic        as_sub;

  md_addsub u_addsub (
    .x   (as_x),
    .y   (as_y),
    .sub (as_sub),
    .sum (as_sum)
  );

  always_comb begin
    as_x   = acc_q;
    as_y   = '0;
    as_sub = 1'b0;
    if (state_q == DIV_RUN) begin
      as_x   = {acc_q[31:0], qr_q[31]};
      as_y   = mcand_q;
      as_sub = 1'b1;
    end else begin
      unique case ({qr_q[0], qm1_q})
        2'b01:   as_y = mcand_q;
        2'b10: begin
          as_y   = mcand_q;
          as_sub = 1'b1;
        end
        default: as_y = '0;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    qr_d       = qr_q;
    qm1_d      = qm1_q;
    mcand_d    = mcand_q;
    is_div_d   = is_div_q;
    zero_div_d = zero_div_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div0_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (mult_div == MD_MULT) begin
          state_d    = MULT_RUN;
          acc_d      = '0;
          qr_d       = b;
          qm1_d      = 1'b0;
          mcand_d    = {a[31], a};
          is_div_d   = 1'b0;
          zero_div_d = 1'b0;
        end else if (mult_div == MD_DIV) begin
          state_d    = (b == '0) ? FINISH : DIV_RUN;
          acc_d      = '0;
          qr_d       = md_abs(a);
          qm1_d      = 1'b0;
          mcand_d    = {1'b0, md_abs(b)};
          is_div_d   = 1'b1;
          zero_div_d = (b == '0);
          neg_quo_d  = a[31] ^ b[31];
          neg_rem_d  = a[31];
        end
      end
      MULT_RUN: begin
        // Arithmetic right shift of {acc, qr, qm1} after the add/sub.
        acc_d = {as_sum[32], as_sum[32:1]};
        qr_d  = {as_sum[0], qr_q[31:1]};
        qm1_d = qr_q[0];
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LastCnt) state_d = FINISH;
      end
      DIV_RUN: begin
        // Negative trial difference means restore the shifted remainder.
        acc_d = as_sum[32] ? as_x : as_sum;
        qr_d  = {qr_q[30:0], ~as_sum[32]};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LastCnt) state_d = FINISH;
      end
      FINISH: begin
        state_d = IDLE;
        done_d  = 1'b1;
        div0_d  = zero_div_q;
        if (!zero_div_q) begin
          if (is_div_q) begin
            hi_d = neg_rem_q ? 32'(32'd0 - acc_q[31:0]) : acc_q[31:0];
            lo_d = neg_quo_q ? 32'(32'd0 - qr_q) : qr_q;
          end else begin
            hi_d = acc_q[31:0];
            lo_d = qr_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      qr_q       <= '0;
      qm1_q      <= 1'b0;
      mcand_q    <= '0;
      is_div_q   <= 1'b0;
      zero_div_q <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div0_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      qr_q       <= qr_d;
      qm1_q      <= qm1_d;
      mcand_q    <= mcand_d;
      is_div_q   <= is_div_d;
      zero_div_q <= zero_div_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div0_q     <= div0_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign div0 = div0_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: arithmetic reference model with a cycle countdown,
// checked every cycle, plus literal expectations for the directed cases.
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  mult_div = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] hi, lo;
  logic        busy, done, div0;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          rem = 0;
  logic [63:0] p_res = '0;
  logic        p_div0 = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic        m_done = 1'b0, m_div0 = 1'b0;

  mult_div_unit dut (
    .clock    (clock),
    .reset    (reset),
    .mult_div (mult_div),
    .a        (a),
    .b        (b),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done),
    .div0     (div0)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    return p;
  endfunction

  // Returns {remainder, quotient}; 64-bit math keeps MIN/-1 well defined.
  function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    q  = sx / sy;
    r  = sx % sy;
    return {r[31:0], q[31:0]};
  endfunction

  // Result appears 33 edges after acceptance (1 edge for divide-by-zero).
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      rem    <= 0;
      p_res  <= '0;
      p_div0 <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_done <= 1'b0;
      m_div0 <= 1'b0;
    end else begin
      m_done <= 1'b0;
      m_div0 <= 1'b0;
      if (rem > 0) begin
        rem <= rem - 1;
        if (rem == 1) begin
          m_done <= 1'b1;
          m_div0 <= p_div0;
          if (!p_div0) begin
            m_hi <= p_res[63:32];
            m_lo <= p_res[31:0];
          end
        end
      end else if (mult_div == 2'b01) begin
        p_res  <= ref_mul(a, b);
        p_div0 <= 1'b0;
        rem    <= 33;
      end else if (mult_div == 2'b10) begin
        if (b == '0) begin
          p_div0 <= 1'b1;
          rem    <= 1;
        end else begin
          p_res  <= ref_div(a, b);
          p_div0 <= 1'b0;
          rem    <= 33;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    chk("busy", 64'(busy), 64'(rem > 0));
    chk("done", 64'(done), 64'(m_done));
    chk("div0", 64'(div0), 64'(m_div0));
    chk("hi", 64'(hi), 64'(m_hi));
    chk("lo", 64'(lo), 64'(m_lo));
  endtask

  task automatic issue_now(input logic [1:0] cmd, input logic [31:0] x, input logic [31:0] y);
    mult_div = cmd;
    a        = x;
    b        = y;
    tick();
    mult_div = 2'b00;
  endtask

  task automatic issue(input logic [1:0] cmd, input logic [31:0] x, input logic [31:0] y);
    tick();
    issue_now(cmd, x, y);
  endtask

  task automatic wait_done(output int edges, output int bcyc);
    edges = 0;
    bcyc  = 0;
    while (!done && edges < 100) begin
      if (busy) bcyc++;
      tick();
      edges++;
    end
    if (!done) chk("done_timeout", 64'(done), 64'd1);
  endtask

  int edges, bcyc;

  initial begin
    #1 reset = 1'b0;
    #2;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    tick();

    // 7 * -3, then a back-to-back MIN*MIN issued in the done cycle
    issue(2'b01, 32'd7, 32'hFFFF_FFFD);
    wait_done(edges, bcyc);
    chk("mul1_edges", 64'(edges), 64'd33);
    chk("mul1_busy_cycles", 64'(bcyc), 64'd33);
    chk("mul1_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("mul1_lo", 64'(lo), 64'hFFFF_FFEB);
    issue_now(2'b01, 32'h8000_0000, 32'h8000_0000);
    wait_done(edges, bcyc);
    chk("mul2_edges", 64'(edges), 64'd33);
    chk("mul2_hi", 64'(hi), 64'h4000_0000);
    chk("mul2_lo", 64'(lo), 64'h0000_0000);

    // 100 / -7
    issue(2'b10, 32'd100, 32'hFFFF_FFF9);
    wait_done(edges, bcyc);
    chk("div1_lo", 64'(lo), 64'hFFFF_FFF2);
    chk("div1_hi", 64'(hi), 64'h0000_0002);

    // -100 / 7 with a MULT issued at edge 5 that must be ignored
    issue(2'b10, 32'hFFFF_FF9C, 32'd7);
    repeat (4) tick();
    issue_now(2'b01, 32'd3, 32'd4);
    wait_done(edges, bcyc);
    chk("div2_edges_after5", 64'(edges), 64'd28);
    chk("div2_lo", 64'(lo), 64'hFFFF_FFF2);
    chk("div2_hi", 64'(hi), 64'hFFFF_FFFE);
    tick();
    chk("div2_no_restart", 64'(busy), 64'd0);

    // MIN / -1 wraps
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(edges, bcyc);
    chk("wrap_lo", 64'(lo), 64'h8000_0000);
    chk("wrap_hi", 64'(hi), 64'h0000_0000);
    chk("wrap_div0", 64'(div0), 64'd0);

    // Reserved command does nothing
    issue(2'b11, 32'd9, 32'd9);
    chk("cmd11_busy", 64'(busy), 64'd0);
    tick();

    // Preload HI=0x11 LO=0x22 via 0x451 / 0x20, then divide by zero
    issue(2'b10, 32'h0000_0451, 32'h0000_0020);
    wait_done(edges, bcyc);
    chk("pre_hi", 64'(hi), 64'h11);
    chk("pre_lo", 64'(lo), 64'h22);
    issue(2'b10, 32'd5, 32'd0);
    wait_done(edges, bcyc);
    chk("dz_edges", 64'(edges), 64'd1);
    chk("dz_div0", 64'(div0), 64'd1);
    chk("dz_hi", 64'(hi), 64'h11);
    chk("dz_lo", 64'(lo), 64'h22);
    tick();
    chk("dz_div0_pulse", 64'(div0), 64'd0);

    // Reset in the middle of a MULT
    issue(2'b01, 32'h0000_1234, 32'h0000_5678);
    repeat (9) tick();
    @(posedge clock);
    #1 reset = 1'b0;
    #1;
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    repeat (2) tick();
    reset = 1'b1;
    issue_now(2'b01, 32'd3, 32'd4);
    chk("post_rst_accept", 64'(busy), 64'd1);
    wait_done(edges, bcyc);
    chk("post_rst_edges", 64'(edges), 64'd33);
    chk("post_rst_lo", 64'(lo), 64'd12);
    chk("post_rst_hi", 64'(hi), 64'd0);
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
